// File: rtl/nco_multichannel.sv
// nco_multichannel
// Multi-channel direct digital synthesiser behind an Avalon-MM slave.
// Every channel has its own phase accumulator, frequency control word,
// phase offset, waveform mode and amplitude scale. All channels advance
// on a shared programmable sample tick.
//
// Ports:
//   Clk, ResetN           system clock, asynchronous active-low reset
//   ChipSelect/Write/Read Avalon slave strobes
//   Address[4:0]          word address
//   WriteData[31:0]       write data
//   ReadData[31:0]        registered read data, latency 1, held between reads
//   oData                 offset-binary samples, channel c at [c*DATA_W +: DATA_W]
//   oStrobe               one-cycle pulse per channel when its oData slice updates
//
// Register map:
//   0 DIV, 1 RUNMASK, 2 INFO, 3 reserved
//   4*(c+1)+0 CTRL {mode[3:2], clr[1], run[0]}
//   4*(c+1)+1 FCW, +2 PHASE_OFF, +3 AMP (clamped to 256)
module nco_multichannel #(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 24,
  parameter int DATA_W   = 10,
  parameter int LUT_AW   = 8,
  parameter int DIV_W    = 16
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  input  logic                         ChipSelect,
  input  logic                         Write,
  input  logic                         Read,
  input  logic [4:0]                   Address,
  input  logic [31:0]                  WriteData,
  output logic [31:0]                  ReadData,
  output logic [CHANNELS*DATA_W-1:0]   oData,
  output logic [CHANNELS-1:0]          oStrobe
);

  localparam int  LUT_N = 1 << LUT_AW;
  localparam int  MID   = 1 << (DATA_W - 1);
  localparam int  EXT_W = DATA_W + 10;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [31:0] INFO = {8'(CHANNELS), 8'(DATA_W), 8'(PHASE_W), 8'h4E};

  // Full-wave sine table, built at elaboration time. Values are centred on
  // MID with peak amplitude MID-1 so the table never reaches 0 or 2^DATA_W.
  logic [DATA_W-1:0] sine_lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANGLE   = 2.0 * PI * real'(k) / real'(LUT_N);
    localparam real SCALED  = real'(MID - 1) * $sin(ANGLE);
    localparam int  ROUNDED = (SCALED >= 0.0) ? $rtoi(SCALED + 0.5) : -$rtoi(0.5 - SCALED);
    assign sine_lut[k] = DATA_W'(MID + ROUNDED);
  end

  // Bus decode: slot 0 holds the global registers, slot c+1 holds channel c.
  logic       wr_en;
  logic       rd_en;
  logic [2:0] slot;
  logic [1:0] reg_sel;

  assign wr_en   = ChipSelect && Write;
  assign rd_en   = ChipSelect && Read;
  assign slot    = Address[4:2];
  assign reg_sel = Address[1:0];

  logic [DIV_W-1:0]    div_reg;
  logic [DIV_W-1:0]    div_count;
  logic [CHANNELS-1:0] run_vec;
  logic                any_run;
  logic                tick;

  logic [31:0] ctrl_rd [CHANNELS];
  logic [31:0] fcw_rd  [CHANNELS];
  logic [31:0] off_rd  [CHANNELS];
  logic [31:0] amp_rd  [CHANNELS];
  logic [31:0] rd_mux;

  assign any_run = |run_vec;
  assign tick    = any_run && (div_count == div_reg);

  // Sample-tick divider. It idles at 0 while nothing runs so the first tick
  // after a run always lands DIV cycles later; a DIV write restarts it.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      div_reg   <= DIV_W'(49);
      div_count <= '0;
    end else if (wr_en && (Address == 5'd0)) begin
      div_reg   <= WriteData[DIV_W-1:0];
      div_count <= '0;
    end else if (!any_run || tick) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + 1'b1;
    end
  end

  // Read multiplexer; anything not decoded reads as zero.
  always_comb begin
    rd_mux = '0;
    if (slot == 3'd0) begin
      case (reg_sel)
        2'd0:    rd_mux = 32'(div_reg);
        2'd1:    rd_mux = 32'(run_vec);
        2'd2:    rd_mux = INFO;
        default: rd_mux = '0;
      endcase
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (slot == 3'(c + 1)) begin
          case (reg_sel)
            2'd0:    rd_mux = ctrl_rd[c];
            2'd1:    rd_mux = fcw_rd[c];
            2'd2:    rd_mux = off_rd[c];
            default: rd_mux = amp_rd[c];
          endcase
        end
      end
    end
  end

  // Registered read port. Because the mux sees the registers before the
  // edge, a simultaneous read and write returns the pre-write value.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ReadData <= '0;
    end else if (rd_en) begin
      ReadData <= rd_mux;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                     hit;
    logic                     wr_ctrl;
    logic                     wr_fcw;
    logic                     wr_off;
    logic                     wr_amp;
    logic                     clr;
    logic                     run;
    logic [1:0]               mode;
    logic [PHASE_W-1:0]       fcw;
    logic [PHASE_W-1:0]       phase_off;
    logic [8:0]               amp;
    logic [PHASE_W-1:0]       acc;
    logic [PHASE_W-1:0]       acc_next;
    logic                     tick_ch;
    logic [PHASE_W-1:0]       p_s1;
    logic                     v_s1;
    logic [DATA_W-1:0]        wave;
    logic [DATA_W-1:0]        wave_s2;
    logic                     v_s2;
    logic signed [EXT_W-1:0]  diff;
    logic signed [EXT_W-1:0]  prod;
    logic signed [EXT_W-1:0]  scaled;
    logic [DATA_W-1:0]        sample_next;
    logic [DATA_W-1:0]        sample;
    logic                     strobe;
    logic                     unused_phase;

    assign hit      = wr_en && (slot == 3'(c + 1));
    assign wr_ctrl  = hit && (reg_sel == 2'd0);
    assign wr_fcw   = hit && (reg_sel == 2'd1);
    assign wr_off   = hit && (reg_sel == 2'd2);
    assign wr_amp   = hit && (reg_sel == 2'd3);
    assign clr      = wr_ctrl && WriteData[1];
    assign tick_ch  = tick && run;
    // clr beats a simultaneous tick; that tick still issues a sample from 0.
    assign acc_next = clr ? '0 : acc + fcw;

    // Channel control registers. Large AMP writes saturate at unity gain.
    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        run       <= 1'b0;
        mode      <= 2'd0;
        fcw       <= '0;
        phase_off <= '0;
        amp       <= 9'd256;
      end else begin
        if (wr_ctrl) begin
          run  <= WriteData[0];
          mode <= WriteData[3:2];
        end
        if (wr_fcw) fcw <= WriteData[PHASE_W-1:0];
        if (wr_off) phase_off <= WriteData[PHASE_W-1:0];
        if (wr_amp) amp <= (WriteData > 32'd256) ? 9'd256 : WriteData[8:0];
      end
    end

    // Accumulator and S1. The offset is added to the freshly updated phase
    // in the same edge so the accumulator itself never carries the offset.
    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        acc  <= '0;
        p_s1 <= '0;
        v_s1 <= 1'b0;
      end else begin
        v_s1 <= tick_ch;
        if (clr || tick_ch) acc <= acc_next;
        if (tick_ch) p_s1 <= acc_next + phase_off;
      end
    end

    // Waveform selection from the S1 phase.
    always_comb begin
      wave = '0;
      case (mode)
        2'd0:    wave = sine_lut[p_s1[PHASE_W-1 -: LUT_AW]];
        2'd1:    wave = p_s1[PHASE_W-1] ? '0 : '1;
        2'd2:    wave = p_s1[PHASE_W-1] ? ~p_s1[PHASE_W-2 -: DATA_W] : p_s1[PHASE_W-2 -: DATA_W];
        default: wave = p_s1[PHASE_W-1 -: DATA_W];
      endcase
    end

    assign unused_phase = ^p_s1;

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        wave_s2 <= '0;
        v_s2    <= 1'b0;
      end else begin
        v_s2 <= v_s1;
        if (v_s1) wave_s2 <= wave;
      end
    end

    // Amplitude scaling about mid-scale. AMP is 8.8-style gain with 256 as
    // unity; the arithmetic shift floors toward minus infinity.
    always_comb begin
      diff        = $signed(EXT_W'(wave_s2)) - $signed(EXT_W'(MID));
      prod        = diff * $signed(EXT_W'(amp));
      scaled      = prod >>> 8;
      sample_next = DATA_W'(scaled + $signed(EXT_W'(MID)));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
        sample <= DATA_W'(MID);
        strobe <= 1'b0;
      end else begin
        strobe <= v_s2;
        if (v_s2) sample <= sample_next;
      end
    end

    assign run_vec[c]                     = run;
    assign oData[c*DATA_W +: DATA_W]      = sample;
    assign oStrobe[c]                     = strobe;
    assign ctrl_rd[c]                     = 32'({mode, 1'b0, run});
    assign fcw_rd[c]                      = 32'(fcw);
    assign off_rd[c]                      = 32'(phase_off);
    assign amp_rd[c]                      = 32'(amp);
  end

endmodule

// File: tb/tb_nco_multichannel.sv
// tb_nco_multichannel
// Directed bench for nco_multichannel at default parameters
// (2 channels, PHASE_W 24, DATA_W 10, LUT_AW 8, DIV_W 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nco_multichannel;

  logic        Clk;
  logic        ResetN;
  logic        ChipSelect;
  logic        Write;
  logic        Read;
  logic [4:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [19:0] oData;
  logic [1:0]  oStrobe;

  int checks;
  int errors;

  nco_multichannel dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .ChipSelect (ChipSelect),
    .Write      (Write),
    .Read       (Read),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .oData      (oData),
    .oStrobe    (oStrobe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        do_write;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expect_rd;
  } csr_vec_t;

  csr_vec_t vecs [18];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Bus write; called and returns on a falling edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    ChipSelect = 1'b1;
    Write      = 1'b1;
    Address    = addr;
    WriteData  = data;
    @(negedge Clk);
    ChipSelect = 1'b0;
    Write      = 1'b0;
  endtask

  task automatic busRead(input logic [4:0] addr, output logic [31:0] data);
    ChipSelect = 1'b1;
    Read       = 1'b1;
    Address    = addr;
    @(negedge Clk);
    ChipSelect = 1'b0;
    Read       = 1'b0;
    data       = ReadData;
  endtask

  task automatic doReset();
    ResetN = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  logic [31:0] rd;
  logic [9:0]  samp [300];
  int          cyc  [300];
  int          n0;
  int          other_cnt;
  int          first_cyc;
  int          post_cnt;
  logic [9:0]  held;

  initial begin
    checks     = 0;
    errors     = 0;
    ResetN     = 1'b0;
    ChipSelect = 1'b0;
    Write      = 1'b0;
    Read       = 1'b0;
    Address    = '0;
    WriteData  = '0;

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("reset_odata", 32'(oData), 32'({10'd512, 10'd512}));
    checkOutput("reset_strobe", 32'(oStrobe), 32'd0);
    checkOutput("reset_readdata", ReadData, 32'd0);
    ResetN = 1'b1;
    @(negedge Clk);

    // CSR table
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'd49};
    vecs[1]  = '{1'b0, 5'd1,  32'h0,        32'd0};
    vecs[2]  = '{1'b0, 5'd2,  32'h0,        32'h020A184E};
    vecs[3]  = '{1'b1, 5'd3,  32'hFFFFFFFF, 32'd0};
    vecs[4]  = '{1'b0, 5'd4,  32'h0,        32'd0};
    vecs[5]  = '{1'b0, 5'd7,  32'h0,        32'd256};
    vecs[6]  = '{1'b0, 5'd11, 32'h0,        32'd256};
    vecs[7]  = '{1'b1, 5'd5,  32'h12345678, 32'h00345678};
    vecs[8]  = '{1'b1, 5'd6,  32'hFFABCDEF, 32'h00ABCDEF};
    vecs[9]  = '{1'b1, 5'd4,  32'h0000000E, 32'h0000000C};
    vecs[10] = '{1'b1, 5'd7,  32'd300,      32'd256};
    vecs[11] = '{1'b1, 5'd7,  32'd100,      32'd100};
    vecs[12] = '{1'b1, 5'd7,  32'd257,      32'd256};
    vecs[13] = '{1'b1, 5'd12, 32'd5,        32'd0};
    vecs[14] = '{1'b0, 5'd31, 32'h0,        32'd0};
    vecs[15] = '{1'b1, 5'd0,  32'h00012345, 32'h00002345};
    vecs[16] = '{1'b1, 5'd10, 32'hFFFFFFFF, 32'h00FFFFFF};
    vecs[17] = '{1'b0, 5'd1,  32'h0,        32'd0};
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_write) applyStimulus(vecs[i].addr, vecs[i].wdata);
      busRead(vecs[i].addr, rd);
      checkOutput($sformatf("csr_vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].expect_rd);
    end

    // Read and write together return the old value; ReadData then holds.
    ChipSelect = 1'b1;
    Write      = 1'b1;
    Read       = 1'b1;
    Address    = 5'd5;
    WriteData  = 32'hAA;
    @(negedge Clk);
    ChipSelect = 1'b0;
    Write      = 1'b0;
    Read       = 1'b0;
    checkOutput("rw_same_cycle_old", ReadData, 32'h00345678);
    busRead(5'd5, rd);
    checkOutput("rw_same_cycle_new", rd, 32'hAA);
    repeat (3) @(negedge Clk);
    checkOutput("readdata_hold", ReadData, 32'hAA);

    // Sine on ch0 with a tick every cycle
    doReset();
    applyStimulus(5'd0, 32'd0);
    applyStimulus(5'd5, 32'h10000);
    applyStimulus(5'd4, 32'd1);
    n0 = 0; other_cnt = 0; first_cyc = -1;
    for (int k = 1; k <= 262; k++) begin
      @(negedge Clk);
      if (oStrobe[0] && n0 < 300) begin
        if (n0 == 0) first_cyc = k;
        samp[n0] = oData[9:0];
        n0++;
      end
      if (oStrobe[1]) other_cnt++;
    end
    checkOutput("sine_first_strobe_cycle", 32'(first_cyc), 32'd3);
    checkOutput("sine_strobe_count", 32'(n0), 32'd260);
    checkOutput("sine_ch1_idle", 32'(other_cnt), 32'd0);
    checkOutput("sine_lut1", 32'(samp[0]), 32'd525);
    checkOutput("sine_lut2", 32'(samp[1]), 32'd537);
    checkOutput("sine_lut3", 32'(samp[2]), 32'd550);
    checkOutput("sine_lut4", 32'(samp[3]), 32'd562);
    checkOutput("sine_lut64", 32'(samp[63]), 32'd1023);
    checkOutput("sine_lut128", 32'(samp[127]), 32'd512);
    checkOutput("sine_lut192", 32'(samp[191]), 32'd1);
    checkOutput("sine_wrap_lut0", 32'(samp[255]), 32'd512);
    checkOutput("sine_wrap_lut1", 32'(samp[256]), 32'd525);

    // Stopping: in-flight samples drain, then the output holds.
    applyStimulus(5'd4, 32'd0);
    post_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (oStrobe[0]) post_cnt++;
    end
    checkOutput("stop_drain_nonzero", 32'(post_cnt >= 1), 32'd1);
    checkOutput("stop_drain_max3", 32'(post_cnt <= 3), 32'd1);
    held = oData[9:0];
    repeat (4) @(negedge Clk);
    checkOutput("stop_hold_data", 32'(oData[9:0]), 32'(held));
    checkOutput("stop_hold_strobe", 32'(oStrobe), 32'd0);

    // Saw on ch1 with DIV=3
    doReset();
    applyStimulus(5'd0, 32'd3);
    applyStimulus(5'd9, 32'h400000);
    applyStimulus(5'd8, 32'hD);
    n0 = 0; other_cnt = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge Clk);
      if (oStrobe[1] && n0 < 300) begin
        cyc[n0]  = k;
        samp[n0] = oData[19:10];
        n0++;
      end
      if (oStrobe[0]) other_cnt++;
    end
    checkOutput("saw_strobe_count", 32'(n0), 32'd6);
    checkOutput("saw_first_cycle", 32'(cyc[0]), 32'd6);
    checkOutput("saw_period", 32'(cyc[4] - cyc[3]), 32'd4);
    checkOutput("saw_s0", 32'(samp[0]), 32'd256);
    checkOutput("saw_s1", 32'(samp[1]), 32'd512);
    checkOutput("saw_s2", 32'(samp[2]), 32'd768);
    checkOutput("saw_s3", 32'(samp[3]), 32'd0);
    checkOutput("saw_s4", 32'(samp[4]), 32'd256);
    checkOutput("saw_ch0_idle", 32'(other_cnt), 32'd0);

    // Square on ch0 at half amplitude
    doReset();
    applyStimulus(5'd0, 32'd0);
    applyStimulus(5'd5, 32'h800000);
    applyStimulus(5'd7, 32'd128);
    applyStimulus(5'd4, 32'd5);
    n0 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (oStrobe[0] && n0 < 300) begin
        samp[n0] = oData[9:0];
        n0++;
      end
    end
    checkOutput("square_count", 32'(n0), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("square_s%0d", i), 32'(samp[i]), (i % 2 == 0) ? 32'd256 : 32'd767);
    applyStimulus(5'd7, 32'd300);
    busRead(5'd7, rd);
    checkOutput("amp_clamp_300", rd, 32'd256);

    // clr on a tick cycle, then an FCW write on a tick cycle
    doReset();
    applyStimulus(5'd0, 32'd3);
    applyStimulus(5'd5, 32'h100000);
    applyStimulus(5'd6, 32'h300000);
    applyStimulus(5'd4, 32'hD);
    n0 = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge Clk);
      ChipSelect = 1'b0;
      Write      = 1'b0;
      if (oStrobe[0] && n0 < 300) begin
        cyc[n0]  = k;
        samp[n0] = oData[9:0];
        n0++;
      end
      if (k == 11) begin
        ChipSelect = 1'b1; Write = 1'b1; Address = 5'd4; WriteData = 32'hF;
      end
      if (k == 15) begin
        ChipSelect = 1'b1; Write = 1'b1; Address = 5'd5; WriteData = 32'h200000;
      end
    end
    checkOutput("clr_strobe_count", 32'(n0), 32'd5);
    checkOutput("clr_s0", 32'(samp[0]), 32'd256);
    checkOutput("clr_s1", 32'(samp[1]), 32'd320);
    checkOutput("clr_on_tick", 32'(samp[2]), 32'd192);
    checkOutput("fcw_on_tick_old", 32'(samp[3]), 32'd256);
    checkOutput("fcw_new", 32'(samp[4]), 32'd384);
    checkOutput("clr_cycle", 32'(cyc[2]), 32'd14);

    // Asynchronous reset while both channels run
    doReset();
    applyStimulus(5'd0, 32'd0);
    applyStimulus(5'd5, 32'h100000);
    applyStimulus(5'd4, 32'hD);
    applyStimulus(5'd9, 32'h200000);
    applyStimulus(5'd8, 32'hD);
    busRead(5'd1, rd);
    checkOutput("runmask_both", rd, 32'd3);
    repeat (4) @(negedge Clk);
    checkOutput("both_strobing", 32'(oStrobe), 32'd3);
    #2;
    ResetN = 1'b0;
    #1;
    checkOutput("async_reset_odata", 32'(oData), 32'({10'd512, 10'd512}));
    checkOutput("async_reset_strobe", 32'(oStrobe), 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    busRead(5'd4, rd);
    checkOutput("post_reset_ctrl0", rd, 32'd0);
    busRead(5'd7, rd);
    checkOutput("post_reset_amp0", rd, 32'd256);
    busRead(5'd8, rd);
    checkOutput("post_reset_ctrl1", rd, 32'd0);
    busRead(5'd11, rd);
    checkOutput("post_reset_amp1", rd, 32'd256);
    post_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (oStrobe != 2'b00) post_cnt++;
    end
    checkOutput("post_reset_no_strobes", 32'(post_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
